sync_counter_161: RTL and testbench



---
 rtl/sync_counter_161_if.sv | 22 ++
 rtl/sync_counter_161.sv | 51 +++++
 tb/tb_sync_counter_161.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sync_counter_161_if.sv
// Parallel-load/enable/carry bundle of one 161-style counter stage.
// The master modport drives the controls; the counter itself uses slave.
interface sync_counter_161_if #(
  parameter int WIDTH = 4
);
  logic             ldbar;
  logic             ctp;
  logic             ctt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             co;

  modport master (
    output ldbar, ctp, ctt, d,
    input  q, co
  );

  modport slave (
    input  ldbar, ctp, ctt, d,
    output q, co
  );
endinterface

// File: rtl/sync_counter_161.sv
// 74LS161-style presettable binary counter: async clear, sync load, P/T enables, ripple carry.
// Define CO_REGISTERED_EN to take the carry from a predicted-terminal-count flop (glitch-free).
module sync_counter_161 #(
  parameter int WIDTH = 4
) (
  input logic               cp,
  input logic               cr,
  sync_counter_161_if.slave bus
);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;

  // Load outranks counting; D is never looked at unless ldbar is low.
  always_comb begin
    q_nxt = q_r;
    if (!bus.ldbar) begin
      q_nxt = bus.d;
    end else if (bus.ctp && bus.ctt) begin
      q_nxt = q_r + WIDTH'(1);
    end
  end

  always_ff @(posedge cp or posedge cr) begin
    if (cr) begin
      q_r <= '0;
    end else begin
      q_r <= q_nxt;
    end
  end

  assign bus.q = q_r;

`ifdef CO_REGISTERED_EN
  // Holds (q == all ones) for the state q is about to enter, so it lines up with q.
  logic tc_r;

  always_ff @(posedge cp or posedge cr) begin
    if (cr) begin
      tc_r <= 1'b0;
    end else begin
      tc_r <= (q_nxt == ALL_ONES);
    end
  end

  assign bus.co = bus.ctt & tc_r;
`else
  assign bus.co = bus.ctt & (q_r == ALL_ONES);
`endif
endmodule

// File: tb/tb_sync_counter_161.sv
// Randomised and directed bench for sync_counter_161 against an integer reference model.
module tb_sync_counter_161;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic cp;
  logic cr;
  int   n_vec;
  int   n_err;
  int   m_q;

  sync_counter_161_if #(.WIDTH(W)) bus ();

  sync_counter_161 #(.WIDTH(W)) dut (
    .cp  (cp),
    .cr  (cr),
    .bus (bus)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_co();
    return (bus.ctt === 1'b1 && m_q == MAXV) ? 1 : 0;
  endfunction

  // One rising edge: advance the model from the inputs seen at the edge, then compare.
  task automatic tick(input string tag);
    @(posedge cp);
    if (bus.ldbar === 1'b0)
      m_q = int'(bus.d);
    else if (bus.ctp === 1'b1 && bus.ctt === 1'b1)
      m_q = (m_q + 1) % (MAXV + 1);
    #1;
    chk({tag, "_q"}, int'(bus.q), m_q);
    chk({tag, "_co"}, int'(bus.co), exp_co());
  endtask

  // Change inputs away from the edge; the carry must follow ctt immediately.
  task automatic apply(input logic ld, input logic p, input logic t, input logic [W-1:0] dd);
    bus.ldbar = ld;
    bus.ctp   = p;
    bus.ctt   = t;
    bus.d     = dd;
    #1;
    chk("co_comb", int'(bus.co), exp_co());
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_q   = 0;

    // Clear asserted from time zero with the clock running and counting enabled.
    cr        = 1'b1;
    bus.ldbar = 1'b1;
    bus.ctp   = 1'b1;
    bus.ctt   = 1'b1;
    bus.d     = 4'($urandom);
    repeat (3) @(posedge cp);
    #1;
    chk("rst_q", int'(bus.q), 0);
    chk("rst_co", int'(bus.co), 0);
    #2 cr = 1'b0;

    // Load 1100 with enables off, then hold for five edges.
    apply(1'b0, 1'b0, 1'b0, 4'b1100);
    tick("load");
    chk("load_1100", int'(bus.q), 12);
    apply(1'b1, 1'b0, 1'b0, 4'($urandom));
    for (int i = 0; i < 5; i++) tick("hold");
    chk("hold_1100", int'(bus.q), 12);

    // Count through the wrap: 1101 1110 1111 0000 0001.
    apply(1'b1, 1'b1, 1'b1, 4'($urandom));
    tick("cnt");
    tick("cnt");
    tick("cnt");
    chk("at_1111_q", int'(bus.q), 15);
    chk("at_1111_co", int'(bus.co), 1);
    tick("cnt");
    chk("wrap_q", int'(bus.q), 0);
    chk("wrap_co", int'(bus.co), 0);
    tick("cnt");
    chk("after_wrap", int'(bus.q), 1);

    // Terminal count with one enable low at a time.
    apply(1'b0, 1'b0, 1'b1, 4'b1111);
    tick("ld15");
    chk("ld15_co", int'(bus.co), 1);
    apply(1'b1, 1'b1, 1'b0, 4'($urandom));
    chk("ctt0_co", int'(bus.co), 0);
    tick("ctt0");
    chk("ctt0_hold", int'(bus.q), 15);
    apply(1'b1, 1'b0, 1'b1, 4'($urandom));
    tick("ctp0");
    chk("ctp0_hold", int'(bus.q), 15);
    chk("ctp0_co", int'(bus.co), 1);

    // Load overrides counting at 0111.
    apply(1'b0, 1'b0, 1'b0, 4'b0111);
    tick("ld7");
    apply(1'b0, 1'b1, 1'b1, 4'b0011);
    tick("ld3");
    chk("ld_over_cnt", int'(bus.q), 3);

    // Free-run 13 cycles, then clear between edges for 20 ns.
    apply(1'b1, 1'b1, 1'b1, 4'($urandom));
    for (int i = 0; i < 13; i++) tick("free");
    #2 cr = 1'b1;
    m_q = 0;
    #1;
    chk("mid_clr_q", int'(bus.q), 0);
    chk("mid_clr_co", int'(bus.co), 0);
    #19;
    chk("clr_held_q", int'(bus.q), 0);
    cr = 1'b0;
    tick("resume");
    chk("resume_1", int'(bus.q), 1);

    // Random traffic with occasional mid-cycle clear pulses.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        cr = 1'b1;
        m_q = 0;
        #1;
        chk("rnd_clr_q", int'(bus.q), 0);
        cr = 1'b0;
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
